dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Data-cache controller for the MEM stage, directly downstream of the EX/MEM pipeline register. It consumes that register's ALU_result (address), RS2data (store data), MemRead and MemWrite. It serves hits with no stall and raises stall_o on a miss, which freezes the pipeline registers, including EX/MEM through its stall_i. Direct-mapped, write-back, write-allocate, with a 256-bit block interface to off-chip data memory.

Parameters:
IDX_W, 5, index width (2^IDX_W lines)
OFS_W, 5, byte offset width (32-byte / 256-bit block)
TAG_W, 22, tag width = 32 - IDX_W - OFS_W

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  reset: synchronous, active-low
p1_addr_i  input  32  byte address (EX/MEM ALU_result)
p1_data_i  input  32  store data (EX/MEM RS2data)
p1_MemRead_i  input  1  load request
p1_MemWrite_i  input  1  store request
p1_data_o  output  32  load data
p1_stall_o  output  1  pipeline stall
mem_addr_o  output  32  block-aligned memory address
mem_data_o  output  256  writeback block
mem_enable_o  output  1  memory request valid
mem_write_o  output  1  1 = write, 0 = read
mem_ack_i  input  1  one-cycle completion pulse
mem_data_i  input  256  refill block

Behaviour:
- Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2]. addr[1:0] is ignored.
- Request = MemRead | MemWrite. If both are high, the request is treated as a write.
- Hit: line valid and tags equal.
  - Read hit: p1_data_o = selected word, combinational in the same cycle; p1_stall_o = 0.
  - Write hit: at posedge, write the word and set dirty.
- Miss: p1_stall_o = 1 combinationally in the same cycle. p1_stall_o stays 1 until the request becomes a hit.
- No request: p1_stall_o = 0, p1_data_o = 0, no state change.
- FSM states: IDLE, MISS, WRITEBACK, REFILL.
  - IDLE -> MISS on a request that misses.
  - MISS -> WRITEBACK if the victim is valid and dirty; otherwise MISS -> REFILL.
  - WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim block. On mem_ack_i -> REFILL.
  - REFILL: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}. On mem_ack_i: store mem_data_i, set tag, valid = 1, dirty = 0, -> IDLE.
  - Back in IDLE the request re-evaluates as a hit. A write hit then merges the word and sets dirty.
- Memory outputs are Moore functions of state and are held stable until ack.
  - mem_ack_i is ignored outside WRITEBACK/REFILL.
  - Ack latency is unbounded.
- Latency, clean miss with ack at cycle k after REFILL entry:
  - cycle 0: IDLE, stall = 1
  - cycle 1: MISS
  - cycle 2: REFILL
  - cycle 2+k: ack
  - cycle 3+k: IDLE hit, stall = 0
- Reset (rst_i low at posedge):
  - state = IDLE; all valid and dirty bits cleared.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p1_stall_o and p1_data_o are 0 until a request arrives.
  - Tag and data contents are don't-care.
  - Reset mid-WRITEBACK/REFILL abandons the transaction; a late ack is ignored.
- Request inputs must be held stable while p1_stall_o = 1; EX/MEM stall guarantees this.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE/MISS/WRITEBACK/REFILL)
  - IDX_W / OFS_W / TAG_W constants
  - BLOCK_W = 256
  - address field slice functions
- Sub-module dcache_sram: tag, valid and dirty arrays plus 2^IDX_W x 256 data array.
  - Single write port; combinational read; synchronous active-low clear of valid/dirty.
- FSM and hit logic stay in dcache_ctrl.

Test Plan:
1. Reset, read 0x00000104 -> stall = 1 the same cycle. REFILL with mem_addr_o = 0x00000100, mem_write_o = 0. Ack with block word1 = 0x11111111 -> p1_data_o = 0x11111111 and stall = 0 the next cycle.
2. Read 0x0000010C after test 1 -> stall = 0 the same cycle, p1_data_o = block word3, mem_enable_o stays 0.
3. Write 0x00000108 = 0xDEADBEEF (hit) -> no memory traffic. A following read of 0x108 returns 0xDEADBEEF.
4. Read 0x00000500 (index 8, new tag) -> WRITEBACK to mem_addr_o = 0x00000100 with mem_data_o[95:64] = 0xDEADBEEF, then REFILL at 0x00000500, then hit.
5. Refill ack delayed 10 cycles -> mem_enable_o, mem_addr_o and stall stay constant for all 10 cycles. A spurious ack while in IDLE has no effect.
6. Pull rst_i low during REFILL -> next edge: IDLE, mem_enable_o = 0. A later ack is ignored. Read 0x00000104 misses again (valid cleared).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-back, write-allocate
// data cache used in the MEM stage.
// Contents: geometry constants, controller state enum, the address field
// layout, and helpers to split a byte address and form a block address.
package dcache_pkg;

  localparam int IDX_W   = 5;
  localparam int OFS_W   = 5;
  localparam int TAG_W   = 32 - IDX_W - OFS_W;
  localparam int BLOCK_W = 256;
  localparam int LINES   = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    WRITEBACK,
    REFILL
  } state_t;

  // Byte address as seen by the cache: tag | index | word-in-block | byte.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [2:0]       word;
    logic [1:0]       byte_ofs;
  } addr_t;

  function automatic addr_t split_addr(input logic [31:0] addr);
    return addr_t'(addr);
  endfunction

  function automatic logic [31:0] block_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the data cache: per-line tag, valid and dirty bits plus a
// 256-bit data block per line.
// Ports:
//   clk_i, rst_i     clock; synchronous active-low clear of valid/dirty
//   idx_i            line index used for both the read and the write
//   rd_tag_o/rd_valid_o/rd_dirty_o/rd_data_o  combinational read of line idx_i
//   wr_en_i          write the whole line (tag, data, dirty) and set valid
//   wr_tag_i/wr_data_i/wr_dirty_i             values written on wr_en_i
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  input  logic               wr_en_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_data_i,
  input  logic               wr_dirty_i
);

  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [BLOCK_W-1:0] data_d [LINES];

  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = wr_dirty_i;
      tag_d[idx_i]   = wr_tag_i;
      data_d[idx_i]  = wr_data_i;
    end
  end

  // Only the status bits are cleared; tag and data contents are meaningless
  // while a line is invalid, so they are left unreset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, write-back,
// write-allocate, 256-bit block interface to off-chip memory.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-low reset
//   p1_addr_i/p1_data_i              EX/MEM address and store data
//   p1_MemRead_i/p1_MemWrite_i       load / store request
//   p1_data_o, p1_stall_o            load data, pipeline stall
//   mem_addr_o/mem_data_o            block address, writeback block
//   mem_enable_o/mem_write_o         memory request valid, 1 = write
//   mem_ack_i/mem_data_i             completion pulse, refill block
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        p1_addr_i,
  input  logic [31:0]        p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [31:0]        p1_data_o,
  output logic               p1_stall_o,
  output logic [31:0]        mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  input  logic               mem_ack_i,
  input  logic [BLOCK_W-1:0] mem_data_i
);

  state_t state_q, state_d;

  addr_t  req_a;
  logic [1:0] byte_unused;
  logic   req;
  logic   hit;
  logic [7:0] word_bit;

  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic               rd_dirty;
  logic [BLOCK_W-1:0] rd_data;

  logic               wr_en;
  logic [TAG_W-1:0]   wr_tag;
  logic [BLOCK_W-1:0] wr_data;
  logic               wr_dirty;

  assign req_a       = split_addr(p1_addr_i);
  assign byte_unused = req_a.byte_ofs;
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = rd_valid && (rd_tag == req_a.tag);
  assign word_bit    = {req_a.word, 5'b0};

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (req_a.idx),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data),
    .wr_dirty_i (wr_dirty)
  );

  // Stall and load data follow the hit check combinationally; memory
  // outputs depend only on the state (plus the held request/victim line).
  // A store that is also flagged as a load is handled as a store.
  always_comb begin
    state_d      = state_q;
    p1_stall_o   = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    wr_en        = 1'b0;
    wr_tag       = req_a.tag;
    wr_data      = rd_data;
    wr_dirty     = 1'b0;

    if (req && !hit) begin
      p1_stall_o = 1'b1;
    end
    if (req && hit && !p1_MemWrite_i) begin
      p1_data_o = rd_data[word_bit +: 32];
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            state_d = MISS;
          end else if (p1_MemWrite_i) begin
            wr_en                   = 1'b1;
            wr_data[word_bit +: 32] = p1_data_i;
            wr_dirty                = 1'b1;
          end
        end
      end
      MISS: begin
        state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = block_addr(rd_tag, req_a.idx);
        mem_data_o   = rd_data;
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = block_addr(req_a.tag, req_a.idx);
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_data  = mem_data_i;
          wr_dirty = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl. The bench plays the role of
// off-chip memory, supplying hand-built refill blocks and checking the
// requests the controller issues.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  logic [255:0] blk1, blk1_wb, blk2, blk4, blk4_wb;

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Hard stop so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = data;
  endtask

  // Wait (bounded) for a memory request, check it, hold it for 'delay'
  // cycles checking it stays put, then return one ack pulse with 'blk'.
  task automatic serviceMem(input string name, input logic exp_wr,
                            input logic [31:0] exp_addr,
                            input logic [255:0] exp_wdata,
                            input int delay, input logic [255:0] blk);
    int waited = 0;
    while (!mem_enable_o && waited < 8) begin
      tick();
      waited++;
    end
    if (!mem_enable_o) begin
      checkOutput({name, "_req_timeout"}, 256'(mem_enable_o), 256'(1));
      return;
    end
    checkOutput({name, "_mem_write"}, 256'(mem_write_o), 256'(exp_wr));
    checkOutput({name, "_mem_addr"}, 256'(mem_addr_o), 256'(exp_addr));
    if (exp_wr) checkOutput({name, "_mem_wdata"}, mem_data_o, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      tick();
      checkOutput({name, "_hold_en"}, 256'(mem_enable_o), 256'(1));
      checkOutput({name, "_hold_addr"}, 256'(mem_addr_o), 256'(exp_addr));
      checkOutput({name, "_hold_stall"}, 256'(p1_stall_o), 256'(1));
    end
    mem_data_i = blk;
    mem_ack_i  = 1'b1;
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      blk1[i*32 +: 32] = 32'h11111111 * i;
      blk2[i*32 +: 32] = 32'hA0000000 + i;
      blk4[i*32 +: 32] = 32'h55555555;
    end
    blk1_wb = blk1;
    blk1_wb[95:64] = 32'hDEADBEEF;
    blk4_wb = blk4;
    blk4_wb[63:32] = 32'hCAFEF00D;

    rst_i      = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("rst_data", 256'(p1_data_o), 256'(0));
    checkOutput("rst_mem_en", 256'(mem_enable_o), 256'(0));
    checkOutput("rst_mem_wr", 256'(mem_write_o), 256'(0));
    checkOutput("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    checkOutput("rst_mem_data", mem_data_o, 256'(0));
    rst_i = 1'b1;
    tick();

    // Cold read miss with cycle-exact latency, ack in the first REFILL cycle.
    applyStimulus(1'b1, 1'b0, 32'h00000104, 32'h0);
    #1;
    checkOutput("t1_stall_c0", 256'(p1_stall_o), 256'(1));
    tick();
    checkOutput("t1_miss_en", 256'(mem_enable_o), 256'(0));
    checkOutput("t1_miss_stall", 256'(p1_stall_o), 256'(1));
    tick();
    checkOutput("t1_refill_en", 256'(mem_enable_o), 256'(1));
    checkOutput("t1_refill_wr", 256'(mem_write_o), 256'(0));
    checkOutput("t1_refill_addr", 256'(mem_addr_o), 256'(32'h00000100));
    mem_data_i = blk1;
    mem_ack_i  = 1'b1;
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    checkOutput("t1_hit_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t1_hit_data", 256'(p1_data_o), 256'(32'h11111111));
    checkOutput("t1_idle_en", 256'(mem_enable_o), 256'(0));

    // Read hit on another word of the same block.
    applyStimulus(1'b1, 1'b0, 32'h0000010C, 32'h0);
    #1;
    checkOutput("t2_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t2_data", 256'(p1_data_o), 256'(32'h33333333));
    tick();
    checkOutput("t2_mem_en", 256'(mem_enable_o), 256'(0));

    // Write hit, then read it back.
    applyStimulus(1'b0, 1'b1, 32'h00000108, 32'hDEADBEEF);
    #1;
    checkOutput("t3_wr_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t3_wr_mem_en", 256'(mem_enable_o), 256'(0));
    tick();
    applyStimulus(1'b1, 1'b0, 32'h00000108, 32'h0);
    #1;
    checkOutput("t3_rd_data", 256'(p1_data_o), 256'(32'hDEADBEEF));
    checkOutput("t3_rd_stall", 256'(p1_stall_o), 256'(0));
    tick();

    // Conflict miss on a dirty line: writeback then refill.
    applyStimulus(1'b1, 1'b0, 32'h00000500, 32'h0);
    #1;
    checkOutput("t4_stall", 256'(p1_stall_o), 256'(1));
    serviceMem("t4_wb", 1'b1, 32'h00000100, blk1_wb, 0, '0);
    serviceMem("t4_rf", 1'b0, 32'h00000500, '0, 0, blk2);
    checkOutput("t4_hit_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t4_hit_data", 256'(p1_data_o), 256'(32'hA0000000));

    // Clean victim: straight to refill, ack held off 10 cycles.
    applyStimulus(1'b1, 1'b0, 32'h0000010C, 32'h0);
    #1;
    checkOutput("t5_stall", 256'(p1_stall_o), 256'(1));
    tick();
    tick();
    checkOutput("t5_no_wb", 256'(mem_write_o), 256'(0));
    serviceMem("t5_rf", 1'b0, 32'h00000100, '0, 10, blk1_wb);
    checkOutput("t5_hit_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t5_hit_data", 256'(p1_data_o), 256'(32'h33333333));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mem_data_i = {8{32'hBAD0BAD0}};
    mem_ack_i  = 1'b1;
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    checkOutput("t5_spur_en", 256'(mem_enable_o), 256'(0));
    applyStimulus(1'b1, 1'b0, 32'h00000108, 32'h0);
    #1;
    checkOutput("t5_spur_stall", 256'(p1_stall_o), 256'(0));
    checkOutput("t5_spur_data", 256'(p1_data_o), 256'(32'hDEADBEEF));
    tick();

    // Write miss with both strobes high: allocate, merge, then evict dirty.
    applyStimulus(1'b1, 1'b1, 32'h00000124, 32'hCAFEF00D);
    #1;
    checkOutput("wa_stall", 256'(p1_stall_o), 256'(1));
    serviceMem("wa_rf", 1'b0, 32'h00000120, '0, 2, blk4);
    checkOutput("wa_hit_stall", 256'(p1_stall_o), 256'(0));
    tick();
    applyStimulus(1'b1, 1'b0, 32'h00000124, 32'h0);
    #1;
    checkOutput("wa_rd_merged", 256'(p1_data_o), 256'(32'hCAFEF00D));
    applyStimulus(1'b1, 1'b0, 32'h00000120, 32'h0);
    #1;
    checkOutput("wa_rd_other", 256'(p1_data_o), 256'(32'h55555555));
    tick();
    applyStimulus(1'b1, 1'b0, 32'h00000524, 32'h0);
    serviceMem("wa_wb", 1'b1, 32'h00000120, blk4_wb, 0, '0);
    serviceMem("wa_rf2", 1'b0, 32'h00000520, '0, 0, blk2);
    checkOutput("wa_rd2_data", 256'(p1_data_o), 256'(32'hA0000001));

    // Reset in the middle of a refill; late ack must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h00000904, 32'h0);
    tick();
    tick();
    checkOutput("t6_refill_en", 256'(mem_enable_o), 256'(1));
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t6_rst_en", 256'(mem_enable_o), 256'(0));
    checkOutput("t6_rst_stall", 256'(p1_stall_o), 256'(0));
    rst_i = 1'b1;
    mem_data_i = {8{32'hBAD0BAD0}};
    mem_ack_i  = 1'b1;
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    checkOutput("t6_late_ack_en", 256'(mem_enable_o), 256'(0));
    applyStimulus(1'b1, 1'b0, 32'h00000104, 32'h0);
    #1;
    checkOutput("t6_remiss_stall", 256'(p1_stall_o), 256'(1));
    serviceMem("t6_rf", 1'b0, 32'h00000100, '0, 0, blk1);
    checkOutput("t6_hit_data", 256'(p1_data_o), 256'(32'h11111111));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t6_idle_data", 256'(p1_data_o), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
